// File: rtl/fir_pkg.sv
// Shared types and arithmetic for the fir filter and its output stage.
// Holds the accumulator/sample typedefs and the round-half-up + saturate helper.
package fir_pkg;

    localparam int ACC_W    = 39;
    localparam int SAMPLE_W = 16;

    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // One extra bit so that adding the rounding bias can never overflow.
    typedef logic signed [ACC_W:0]      acc_wide_t;

    typedef struct packed {
        sample_t sample;
        logic    clip;
    } sat_round_t;

    // Sample range limits, sign-extended to the wide rounding width.
    localparam acc_wide_t WIDE_MAX = {{(ACC_W + 1 - SAMPLE_W){1'b0}}, 1'b0, {(SAMPLE_W - 1){1'b1}}};
    localparam acc_wide_t WIDE_MIN = {{(ACC_W + 1 - SAMPLE_W){1'b1}}, 1'b1, {(SAMPLE_W - 1){1'b0}}};

    // Round half-up by 'shift' bits, then clip to the signed sample range.
    // 'shift' is expected to be an elaboration-time constant (1..ACC_W-SAMPLE_W).
    function automatic sat_round_t sat_round(input acc_t acc, input int shift);
        acc_wide_t  ext;
        acc_wide_t  bias;
        acc_wide_t  r;
        sat_round_t res;
        ext  = {acc[ACC_W-1], acc};
        bias = acc_wide_t'({{ACC_W{1'b0}}, 1'b1} << (shift - 1));
        r    = (ext + bias) >>> shift;
        if (r > WIDE_MAX) begin
            res.sample = {1'b0, {(SAMPLE_W - 1){1'b1}}};
            res.clip   = 1'b1;
        end else if (r < WIDE_MIN) begin
            res.sample = {1'b1, {(SAMPLE_W - 1){1'b0}}};
            res.clip   = 1'b1;
        end else begin
            res.sample = r[SAMPLE_W-1:0];
            res.clip   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/full/empty.
// The head is presented combinationally from storage and reads as zero when empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fir_out_stage.sv
// Output stage after the fir filter: round/saturate each accumulator result,
// decimate, register once, and buffer kept samples in a valid/ready FIFO.
// Also tracks clipped-sample count and a sticky drop flag for debug.
module fir_out_stage #(
    parameter int ACC_W = fir_pkg::ACC_W,
    parameter int OUT_W = fir_pkg::SAMPLE_W,
    parameter int SHIFT = 15,
    parameter int DECIM = 2,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             sat_count,
    output logic                    drop_flag,
    input  logic                    clr_status
);

    import fir_pkg::*;

    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PHASE_W-1:0]      phase_reg;
    logic                    keep;
    sat_round_t              rounded;

    logic                    s1_valid_reg;
    logic signed [OUT_W-1:0] s1_data_reg;

    logic [15:0]             sat_count_reg;
    logic                    drop_flag_reg;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;

    assign keep    = ena && (phase_reg == '0);
    assign rounded = sat_round(acc, SHIFT);

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A staged sample is lost only when the FIFO is full and nothing leaves this cycle.
    assign drop      = s1_valid_reg && fifo_full && !pop;

    assign sat_count = sat_count_reg;
    assign drop_flag = drop_flag_reg;

    // Decimation phase: counts ena strobes modulo DECIM; phase 0 marks a kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= '0;
        end else if (ena) begin
            if (phase_reg == PHASE_W'(DECIM - 1)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    // S1: register the rounded/saturated kept sample and its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= keep;
            if (keep) begin
                s1_data_reg <= rounded.sample;
            end
        end
    end

    // Clip counter: counts clipped kept samples as they enter S1, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_reg <= '0;
        end else if (clr_status) begin
            sat_count_reg <= '0;
        end else if (keep && rounded.clip && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 1'b1;
        end
    end

    // Sticky drop flag: set when a staged sample cannot enter the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_flag_reg <= 1'b0;
        end else if (clr_status) begin
            drop_flag_reg <= 1'b0;
        end else if (drop) begin
            drop_flag_reg <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_reg),
        .push_data (s1_data_reg),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Output stage directly downstream of the `fir` filter. It takes the 39-bit accumulator result on every filter enable and rounds it half-up by a fixed right shift. It then saturates the result to 16-bit signed, decimates by a fixed ratio, and buffers the kept samples in a small FIFO with a valid/ready interface toward the DAC/serializer side. It also reports saturation and overflow-drop status for debug.

## Interface
- `ACC_W`, 39, accumulator width from `fir`.
- `OUT_W`, 16, output sample width, signed.
- `SHIFT`, 15, right-shift applied after rounding; 1 ≤ SHIFT ≤ ACC_W-OUT_W.
- `DECIM`, 2, decimation ratio; 1 = pass every sample.
- `DEPTH`, 8, FIFO depth; power of two, ≥ 2.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  accumulator valid strobe; same signal that drives `fir.ena`.
- `acc`  in  ACC_W  signed `fir.out`, sampled when `ena`=1.
- `out_data`  out  OUT_W  signed FIFO head sample.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head when `out_valid`&&`out_ready`.
- `sat_count`  out  16  saturating count of clipped kept samples.
- `drop_flag`  out  1  sticky; set when a kept sample is lost to a full FIFO.
- `clr_status`  in  1  clears `sat_count` and `drop_flag`; takes priority over same-cycle increment/set.

## Operation
- Decimation: a phase counter runs 0..DECIM-1 and advances on each `ena`. A sample is kept when phase==0, so the first `ena` after reset is kept, then every DECIM-th. Non-kept samples are discarded with no side effects.
- Rounding: r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_W+1 bits so no intermediate overflow occurs. This is round-half-up, so -0.5 LSB rounds to 0.
- Saturation: r > 2^(OUT_W-1)-1 clips to 32767; r < -2^(OUT_W-1) clips to -32768. Each clip on a kept sample increments `sat_count`, which holds at 0xFFFF.
- Stage register: the kept rounded/saturated value and its valid bit are registered once (S1).
- FIFO write: S1 valid writes the FIFO on the next edge.
  - If the FIFO is full and no pop occurs that cycle, the sample is dropped and `drop_flag` is set.
  - Full with a simultaneous pop: the write succeeds and the count is unchanged.
- FIFO read: a pop happens on `out_valid`&&`out_ready`. `out_data` shows the head combinationally from storage, and is stable while `out_valid`=1 and `out_ready`=0.
- Empty with `out_ready`=1: no effect. Pointers wrap modulo DEPTH; the count runs 0..DEPTH.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sat_count`=0, `drop_flag`=0. FIFO is empty, S1 is invalid, and the phase counter is 0.
- `ena` asserted in the same cycle as `rst` is ignored.
- Latency: with `ena`=1 in cycle t, the kept sample is in S1 after edge t. It is written to the FIFO at edge t+1, and `out_valid`=1 with `out_data` equal to the sample in cycle t+2 (FIFO previously empty).
- Throughput: one kept sample per cycle; `ena` can be high every cycle.
- `rst` mid-operation: buffered data and the S1 contents are discarded. All state returns to reset values on that edge.

## Structure
- Package `fir_pkg` holds `ACC_W`, `SAMPLE_W`=16, the typedefs `acc_t` (logic signed [ACC_W-1:0]) and `sample_t` (logic signed [15:0]), and a `sat_round` function (acc_t → sample_t plus a clip flag) parameterised by the shift. These are shared with `fir` and its bench.
- Sub-module `sync_fifo`: parameterised width/depth, one clock, synchronous reset, push/pop/full/empty. It is reused elsewhere.
- Top level contains only the decimation counter, S1, the status counters, and the FIFO instance.

## Test plan
- Rounding/saturation, DECIM=1, `out_ready`=1, acc inputs 16384, -16384, 1073709056, 1073741824, -2^38, applied one per cycle:
  - `out_data` = 1, 0, 32767, 32767, -32768, starting 2 cycles after the first `ena`.
  - `sat_count`=2.
- Decimation DECIM=2, 6 consecutive `ena` with acc = k<<15 for k=1..6: outputs are 1, 3, 5 only.
- Backpressure and full:
  - `out_ready`=0 with 10 kept samples pushed: `out_valid` stays high, `out_data` holds the first sample, and after the 9th sample `drop_flag`=1.
  - Then draining gives exactly 8 samples, in order.
- Full with simultaneous pop, `out_ready`=1 while full: an incoming sample is written, `drop_flag` stays 0, and the count stays 8.
- Reset mid-stream: with 4 samples buffered, assert `rst` for 1 cycle. In the next cycle `out_valid`=0 and `sat_count`=0. The next `ena` is kept (phase 0) and appears 2 cycles later.
- `clr_status` asserted in the same cycle as a clipping kept sample reaches S1: `sat_count` reads 0 afterward.
